// File: rtl/ad_read_ctrl.sv
// -----------------------------------------------------------------------------
// ad_read_ctrl
//
// Reads frames from a serial ADC through an external WORD_BITS-stage shift
// register. When the ADC signals data-ready (drdy_n falling), the controller
// produces WORD_BITS sclk_out pulses per word and keeps s2p_en high while
// shifting. After each word it waits two cycles for the shift register to
// settle, then latches parallel_in. A frame is NUM_WORDS words: word 0 is
// status and words 1..NUM_WORDS-1 are channels.
//
// Parameters
//   SCLK_DIV    : clk cycles per sclk_out half-period (2..255)
//   WORD_BITS   : bits per ADC word
//   NUM_WORDS   : words per frame (1..15)
//   TIMEOUT_CYC : DRDY watchdog limit in clk cycles
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   enable      in   1 = accept frames; 0 = finish current frame, then idle
//   drdy_n      in   ADC data-ready, asynchronous, active-low
//   parallel_in in   parallel word from the external shift register
//   sclk_out    out  serial clock to the ADC and the shift register
//   s2p_en      out  shift enable to the shift register
//   word_out    out  captured word, held between word_valid pulses
//   word_valid  out  one-clk pulse: word_out/word_idx are valid
//   word_idx    out  index of the word within its frame (0 = status)
//   frame_done  out  one-clk pulse with the last word_valid of a frame
//   busy        out  high while a frame is being read
//   overrun     out  sticky: drdy_n fell while busy
//   timeout     out  sticky: DRDY watchdog expired
//
// Build option
//   AD_READ_CTRL_DRDY_TIMEOUT_EN : when defined, a watchdog counts cycles
//   spent waiting in ARM and sets timeout at TIMEOUT_CYC. When undefined,
//   there is no watchdog logic and timeout is tied low.
// -----------------------------------------------------------------------------
module ad_read_ctrl #(
    parameter int unsigned SCLK_DIV    = 4,
    parameter int unsigned WORD_BITS   = 24,
    parameter int unsigned NUM_WORDS   = 9,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 drdy_n,
    input  logic [WORD_BITS-1:0] parallel_in,
    output logic                 sclk_out,
    output logic                 s2p_en,
    output logic [WORD_BITS-1:0] word_out,
    output logic                 word_valid,
    output logic [3:0]           word_idx,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout
);

    // Elaboration-time parameter sanity checks.
    if (SCLK_DIV < 2 || SCLK_DIV > 255) begin : g_chk_sclk_div
        $error("ad_read_ctrl: SCLK_DIV must be in 2..255");
    end
    if (NUM_WORDS < 1 || NUM_WORDS > 15) begin : g_chk_num_words
        $error("ad_read_ctrl: NUM_WORDS must be in 1..15");
    end
    if (WORD_BITS < 1) begin : g_chk_word_bits
        $error("ad_read_ctrl: WORD_BITS must be at least 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_chk_timeout
        $error("ad_read_ctrl: TIMEOUT_CYC must be at least 1");
    end

    localparam int unsigned      BIT_W     = $clog2(WORD_BITS + 1);
    localparam logic [7:0]       DIV_LAST  = 8'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(WORD_BITS - 1);
    localparam logic [3:0]       WORD_LAST = 4'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_CAPTURE,
        S_GAP
    } state_t;

    state_t state;
    state_t state_next;

    logic             drdy_s1;
    logic             drdy_s2;
    logic             drdy_prev;
    logic             drdy_fall;

    logic [7:0]       div_cnt;
    logic             div_done;
    logic             div_run;
    logic [BIT_W-1:0] bit_cnt;
    logic [3:0]       word_cnt;
    logic             cap_cnt;
    logic             cap_fire;
    logic             last_word;

    // -------------------------------------------------------------------------
    // drdy_n synchronizer and falling-edge detector. The idle level is high,
    // so every stage resets to 1 and a reset cannot fake an edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drdy_s1   <= 1'b1;
            drdy_s2   <= 1'b1;
            drdy_prev <= 1'b1;
        end else begin
            drdy_s1   <= drdy_n;
            drdy_s2   <= drdy_s1;
            drdy_prev <= drdy_s2;
        end
    end

    assign drdy_fall = drdy_prev & ~drdy_s2;

    // -------------------------------------------------------------------------
    // Decodes shared by the FSM and the datapath
    // -------------------------------------------------------------------------
    assign div_run   = (state == S_SHIFT_HI) || (state == S_SHIFT_LO) || (state == S_GAP);
    assign div_done  = (div_cnt == DIV_LAST);
    assign cap_fire  = (state == S_CAPTURE) && cap_cnt;
    assign last_word = (word_cnt == WORD_LAST);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (enable) begin
                    state_next = S_ARM;
                end
            end
            S_ARM: begin
                if (!enable) begin
                    state_next = S_IDLE;
                end else if (drdy_fall) begin
                    state_next = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (div_done) begin
                    state_next = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                // The bit counter increments on this exit, so comparing
                // against WORD_BITS-1 here tests the post-increment count.
                if (div_done) begin
                    state_next = (bit_cnt == BITS_LAST) ? S_CAPTURE : S_SHIFT_HI;
                end
            end
            S_CAPTURE: begin
                if (cap_cnt) begin
                    if (!last_word) begin
                        state_next = S_GAP;
                    end else if (enable) begin
                        state_next = S_ARM;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (div_done) begin
                    state_next = S_SHIFT_HI;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from state
    // -------------------------------------------------------------------------
    always_comb begin
        sclk_out = (state == S_SHIFT_HI);
        s2p_en   = (state == S_SHIFT_HI) || (state == S_SHIFT_LO);
        busy     = (state != S_IDLE) && (state != S_ARM);
    end

    // -------------------------------------------------------------------------
    // Half-period divider: counts only in the timed states and wraps at
    // SCLK_DIV-1, which is also the cycle on which those states exit.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_run && !div_done) begin
            div_cnt <= div_cnt + 1'b1;
        end else begin
            div_cnt <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Capture dwell, bit counter and word counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_cnt  <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            cap_cnt <= (state == S_CAPTURE) ? ~cap_cnt : 1'b0;
            if (cap_fire) begin
                bit_cnt  <= '0;
                word_cnt <= last_word ? 4'd0 : word_cnt + 1'b1;
            end else if ((state == S_SHIFT_LO) && div_done) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Captured word and its strobes. The latch happens on the second CAPTURE
    // cycle, so word_valid is visible on the cycle that follows it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_out   <= '0;
            word_idx   <= '0;
            word_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            word_valid <= cap_fire;
            frame_done <= cap_fire && last_word;
            if (cap_fire) begin
                word_out <= parallel_in;
                word_idx <= word_cnt;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sticky overrun: a data-ready edge during a read is otherwise ignored.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (drdy_fall && busy) begin
            overrun <= 1'b1;
        end
    end

`ifdef AD_READ_CTRL_DRDY_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // DRDY watchdog: counts ARM cycles without a data-ready edge and
    // saturates at TIMEOUT_CYC. The FSM keeps waiting after it fires.
    // -------------------------------------------------------------------------
    localparam int unsigned    WD_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= '0;
            timeout_r <= 1'b0;
        end else begin
            if ((state != S_ARM) || drdy_fall) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_cnt == WD_MAX) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/ad_read_ctrl.md
AD_READ_CTRL -- requirements
Module: ad_read_ctrl

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal range 2..255).
REQ-002 SHALL have parameter WORD_BITS, default 24, meaning bits per ADC word.
REQ-003 SHALL have parameter NUM_WORDS, default 9, meaning words per frame (1 status + 8 channels; legal range 1..15).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1000000, meaning the DRDY watchdog limit in clk cycles.
REQ-005 clk  in  1  system clock; all logic runs on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  high = accept frames; low = finish the current frame, then idle.
REQ-008 drdy_n  in  1  ADC data-ready, asynchronous, active-low.
REQ-009 parallel_in  in  WORD_BITS  parallel word from the external 24-stage shift register.
REQ-010 sclk_out  out  1  serial clock to the ADC and to the shift register clock.
REQ-011 s2p_en  out  1  shift-enable to the shift register.
REQ-012 word_out  out  WORD_BITS  captured word.
REQ-013 word_valid  out  1  one-clk pulse marking word_out/word_idx valid.
REQ-014 word_idx  out  4  index of the word within its frame (0 = status).
REQ-015 frame_done  out  1  one-clk pulse coincident with the last word_valid of a frame.
REQ-016 busy  out  1  high while not in IDLE or ARM.
REQ-017 overrun  out  1  sticky flag: DRDY fell while busy.
REQ-018 timeout  out  1  sticky flag: watchdog expired (DRDY_TIMEOUT_EN only).

Function
REQ-019 SHALL synchronize drdy_n through 2 flops and detect a falling edge on the synchronized value.
REQ-020 SHALL implement states IDLE, ARM, SHIFT_HI, SHIFT_LO, CAPTURE, GAP.
REQ-021 IDLE->ARM when enable=1; ARM->IDLE when enable=0; ARM->SHIFT_HI on a DRDY falling edge.
REQ-022 SHIFT_HI: sclk_out=1 for SCLK_DIV cycles, then ->SHIFT_LO; SHIFT_LO: sclk_out=0 for SCLK_DIV cycles.
REQ-023 Bit counter SHALL increment at SHIFT_LO exit; SHIFT_LO->SHIFT_HI if count<WORD_BITS, else ->CAPTURE.
REQ-024 s2p_en SHALL be 1 only in SHIFT_HI and SHIFT_LO, so exactly WORD_BITS rising sclk_out edges occur per word.
REQ-025 CAPTURE: stay 2 cycles (shift-register settling); on the 2nd cycle latch parallel_in into word_out and pulse word_valid with word_idx = word counter.
REQ-026 After CAPTURE, if word counter < NUM_WORDS-1: increment it, clear the bit counter, ->GAP. GAP holds sclk_out=0 for SCLK_DIV cycles, then ->SHIFT_HI.
REQ-027 On the last word, pulse frame_done with word_valid, clear both counters, ->ARM if enable=1, else ->IDLE.
REQ-028 enable deasserting mid-frame SHALL NOT abort the frame.
REQ-029 A DRDY falling edge while busy SHALL set overrun and be otherwise ignored (the frame continues).
REQ-030 A DRDY falling edge in IDLE SHALL be ignored and SHALL NOT set overrun.
REQ-031 word_out SHALL hold its value between word_valid pulses.

Reset
REQ-032 Asserting reset SHALL force state IDLE, clear the counters and synchronizers (sync regs to 1), and drive sclk_out=0, s2p_en=0, word_out=0, word_valid=0, word_idx=0, frame_done=0, busy=0, overrun=0, timeout=0.
REQ-033 Reset mid-frame SHALL abort immediately with no word_valid pulse; after release, the next frame starts only on a fresh DRDY falling edge in ARM.
REQ-034 overrun and timeout SHALL clear only on reset.

Configuration
REQ-035 With macro AD_READ_CTRL_DRDY_TIMEOUT_EN defined, a watchdog counter SHALL run in ARM, clear on each DRDY falling edge and on leaving ARM, and set timeout when it reaches TIMEOUT_CYC; the FSM continues waiting.
REQ-036 Without the macro, no watchdog logic SHALL exist and timeout SHALL be tied to 0.

Verification
REQ-037 Reset, enable=1, DRDY falls, shift register model loaded with 0xA5A5A5 -> 24 sclk_out rising edges with s2p_en=1, then word_valid with word_out=0xA5A5A5 and word_idx=0.
REQ-038 Full frame, NUM_WORDS=9, SCLK_DIV=4 -> 9 word_valid pulses with idx 0..8, frame_done on idx 8, 216 total sclk edges, busy low afterwards.
REQ-039 Second DRDY falling edge during word 3 -> overrun=1, frame completes normally with 9 words.
REQ-040 enable dropped during word 5 -> frame completes, state returns to IDLE, next DRDY edge ignored with overrun=0.
REQ-041 reset asserted during word 2 -> all outputs 0 asynchronously and no word_valid; the next frame captures correctly starting at idx 0.
REQ-042 Macro defined, TIMEOUT_CYC=100, no DRDY -> timeout=1 after 100 cycles in ARM; macro undefined -> timeout stays 0.
